// File: rtl/rename_queue_mw_pkg.sv
// rename_queue_mw_pkg: rename-queue entry width and field layout shared by ID pack, queue and IQ unpack
package rename_queue_mw_pkg;
   localparam int RQ_ENTRY_W = 138;
   localparam int INSTR_MSB  = 137;
   localparam int INSTR_LSB  = 106;
   localparam int PC_MSB     = 105;
   localparam int PC_LSB     = 74;
   localparam int OP_MSB     = 73;
   localparam int OP_LSB     = 68;
   localparam int RS_MSB     = 67;
   localparam int RS_LSB     = 63;
   localparam int RT_MSB     = 62;
   localparam int RT_LSB     = 58;
   localparam int RD_MSB     = 57;
   localparam int RD_LSB     = 53;
   localparam int SA_MSB     = 52;
   localparam int SA_LSB     = 48;
   localparam int FN_MSB     = 47;
   localparam int FN_LSB     = 42;
   localparam int IMM_MSB    = 41;
   localparam int IMM_LSB    = 26;
   localparam int TGT_MSB    = 25;
   localparam int TGT_LSB    = 0;
endpackage

// File: rtl/rename_queue_mw_prefix_cnt.sv
// rename_queue_mw_prefix_cnt: length of the run of ones starting at bit 0
module rename_queue_mw_prefix_cnt #(
   parameter int W = 2
) (
   input  logic [W-1:0]               vec,
   output logic [$clog2(W+1)-1:0]     cnt
);
   localparam int CW = $clog2(W + 1);
   logic run;
   // count lanes until the first gap; anything above a gap is ignored
   always_comb begin
      cnt = '0;
      run = 1'b1;
      for (int i = 0; i < W; i++) begin
         run = run & vec[i];
         cnt = cnt + CW'(run);
      end
   end
endmodule

// File: rtl/rename_queue_mw.sv
// rename_queue_mw: multi-lane in-order circular rename queue between ID and IQ, first-word-fall-through
module rename_queue_mw
   import rename_queue_mw_pkg::*;
#(
   parameter int DEPTH   = 8,
   parameter int ENTRY_W = RQ_ENTRY_W,
   parameter int ENQ_W   = 2,
   parameter int DEQ_W   = 2
) (
   input  logic                          CLK,
   input  logic                          RESET,
   input  logic                          FLUSH,
   input  logic [ENQ_W-1:0]              enq_valid,
   input  logic [ENQ_W*ENTRY_W-1:0]      enq_data,
   output logic                          enq_ready,
   output logic [DEQ_W-1:0]              deq_valid,
   output logic [DEQ_W*ENTRY_W-1:0]      deq_data,
   input  logic [$clog2(DEQ_W+1)-1:0]    deq_take,
   output logic [$clog2(DEPTH+1)-1:0]    count,
   output logic                          full,
   output logic                          empty
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int EW = $clog2(ENQ_W + 1);
   logic [DEPTH-1:0][ENTRY_W-1:0] mem;
   logic [PW-1:0] head_ptr, tail_ptr;
   logic [CW-1:0] cnt, n_deq, count_next;
   logic [EW-1:0] n_prefix, n_enq;
   logic clear;
   rename_queue_mw_prefix_cnt #(.W(ENQ_W)) u_prefix (.vec(enq_valid), .cnt(n_prefix));
   assign clear      = RESET | FLUSH;
   assign enq_ready  = cnt <= CW'(DEPTH - ENQ_W);
   assign n_enq      = enq_ready ? n_prefix : '0;
   assign n_deq      = CW'(deq_take) > cnt ? cnt : CW'(deq_take);
   assign count_next = cnt + CW'(n_enq) - n_deq;
   assign count      = cnt;
   assign full       = cnt == CW'(DEPTH);
   assign empty      = cnt == '0;
   for (genvar j = 0; j < DEQ_W; j++) begin : g_deq
      assign deq_valid[j]                    = cnt > CW'(j);
      assign deq_data[j*ENTRY_W +: ENTRY_W]  = mem[head_ptr + PW'(j)];
   end
   // pointer and occupancy update; RESET and FLUSH both drop the whole queue
   always_ff @(posedge CLK) begin
      if (clear) begin
         head_ptr <= '0;
         tail_ptr <= '0;
         cnt      <= '0;
      end else begin
         head_ptr <= head_ptr + PW'(n_deq);
         tail_ptr <= tail_ptr + PW'(n_enq);
         cnt      <= count_next;
      end
   end
   // accepted lanes land at consecutive slots from the tail, wrapping mod DEPTH; array is never reset
   always_ff @(posedge CLK) begin
      for (int i = 0; i < ENQ_W; i++)
         if (!clear && EW'(i) < n_enq) mem[tail_ptr + PW'(i)] <= enq_data[i*ENTRY_W +: ENTRY_W];
   end
   // occupancy bound and contiguous enqueue lanes
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         assert (cnt <= CW'(DEPTH));
         assert ((enq_valid & (enq_valid + ENQ_W'(1))) == '0);
      end
   end
endmodule

// File: tb/tb_rename_queue_mw.sv
// tb_rename_queue_mw: vector table plus scoreboard check of the multi-lane rename queue
module tb_rename_queue_mw;
   import rename_queue_mw_pkg::*;
   localparam int EW = RQ_ENTRY_W;
   logic            CLK, RESET, FLUSH;
   logic [1:0]      enq_valid, deq_valid, deq_take;
   logic [2*EW-1:0] enq_data, deq_data;
   logic            enq_ready, full, empty;
   logic [3:0]      count;
   int              checks = 0, failures = 0, seq = 'h100;
   logic [EW-1:0]   exp_q[$];
   typedef struct {
      logic       r;
      logic       f;
      logic [1:0] ev;
      logic [1:0] take;
      int         exp_cnt;
   } vec_t;
   vec_t tbl[17];

   rename_queue_mw dut (
      .CLK(CLK), .RESET(RESET), .FLUSH(FLUSH),
      .enq_valid(enq_valid), .enq_data(enq_data), .enq_ready(enq_ready),
      .deq_valid(deq_valid), .deq_data(deq_data), .deq_take(deq_take),
      .count(count), .full(full), .empty(empty)
   );

   initial begin
      CLK = 0;
      forever #5 CLK = ~CLK;
   end

   task automatic chk(input string nm, input logic [EW-1:0] act, input logic [EW-1:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, expv);
      end
   endtask

   task automatic check_outputs(input string nm);
      int sz = exp_q.size();
      logic [1:0] ev_exp;
      ev_exp = {sz > 1, sz > 0};
      chk({nm, " count"}, EW'(count), EW'(sz));
      chk({nm, " full"}, EW'(full), EW'(sz == 8));
      chk({nm, " empty"}, EW'(empty), EW'(sz == 0));
      chk({nm, " enq_ready"}, EW'(enq_ready), EW'(sz <= 6));
      chk({nm, " deq_valid"}, EW'(deq_valid), EW'(ev_exp));
      for (int j = 0; j < 2 && j < sz; j++)
         chk($sformatf("%s deq_data%0d", nm, j), deq_data[j*EW +: EW], exp_q[j]);
   endtask

   task automatic step(input logic r, input logic f, input logic [1:0] ev, input logic [1:0] take,
                       input int exp_cnt, input string nm);
      int sz, acc, nd;
      RESET = r; FLUSH = f; enq_valid = ev; deq_take = take;
      enq_data = {EW'(seq + 1), EW'(seq)};
      if (r || f) exp_q.delete();
      else begin
         sz  = exp_q.size();
         acc = (8 - sz >= 2) ? (ev == 2'b11 ? 2 : ev == 2'b01 ? 1 : 0) : 0;
         nd  = int'(take) < sz ? int'(take) : sz;
         repeat (nd) void'(exp_q.pop_front());
         for (int i = 0; i < acc; i++) exp_q.push_back(EW'(seq + i));
         seq += acc;
      end
      @(posedge CLK);
      #1;
      RESET = 0; FLUSH = 0; enq_valid = 0; deq_take = 0;
      chk({nm, " count_vec"}, EW'(count), EW'(exp_cnt));
      check_outputs(nm);
   endtask

   initial begin
      RESET = 1; FLUSH = 0; enq_valid = 0; deq_take = 0; enq_data = '0;
      tbl[0]  = '{0, 0, 2'b11, 2'd0, 2};
      tbl[1]  = '{0, 0, 2'b11, 2'd0, 4};
      tbl[2]  = '{0, 0, 2'b11, 2'd0, 6};
      tbl[3]  = '{0, 0, 2'b11, 2'd0, 8};
      tbl[4]  = '{0, 0, 2'b11, 2'd0, 8};
      tbl[5]  = '{0, 0, 2'b00, 2'd2, 6};
      tbl[6]  = '{0, 0, 2'b00, 2'd2, 4};
      tbl[7]  = '{0, 0, 2'b00, 2'd2, 2};
      tbl[8]  = '{0, 0, 2'b00, 2'd2, 0};
      tbl[9]  = '{0, 0, 2'b11, 2'd0, 2};
      tbl[10] = '{0, 0, 2'b11, 2'd0, 4};
      tbl[11] = '{0, 0, 2'b11, 2'd0, 6};
      tbl[12] = '{0, 0, 2'b11, 2'd2, 6};
      tbl[13] = '{0, 0, 2'b01, 2'd0, 7};
      tbl[14] = '{0, 0, 2'b11, 2'd2, 5};
      tbl[15] = '{0, 1, 2'b11, 2'd1, 0};
      tbl[16] = '{0, 0, 2'b01, 2'd0, 1};
      step(1, 0, 2'b00, 2'd0, 0, "reset1");
      step(1, 0, 2'b00, 2'd0, 0, "reset2");
      chk("reset empty", EW'(empty), EW'(1));
      chk("reset deq_valid", EW'(deq_valid), EW'(0));
      for (int k = 0; k < 17; k++)
         step(tbl[k].r, tbl[k].f, tbl[k].ev, tbl[k].take, tbl[k].exp_cnt, $sformatf("vec%0d", k));
      step(0, 0, 2'b00, 2'd2, 0, "underflow1");
      step(0, 0, 2'b00, 2'd2, 0, "underflow2");
      step(1, 0, 2'b00, 2'd0, 0, "wrap_reset");
      for (int k = 0; k < 7; k++) step(0, 0, 2'b01, 2'd1, 1, $sformatf("wrap_pre%0d", k));
      step(0, 0, 2'b00, 2'd1, 0, "wrap_drain");
      step(0, 0, 2'b11, 2'd0, 2, "wrap_enq");
      step(0, 0, 2'b00, 2'd2, 0, "wrap_deq");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
